// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache/memory burst bus bundle seen by the arbiter
// master: arbiter view; slave: the caches and memory controller view.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 21
);
  logic                   i_IC_MEM_Valid;
  logic [ADDRESS_WIDTH:0] i_IC_MEM_Address;
  logic                   o_IC_MEM_Valid;
  logic                   o_IC_MEM_Last;
  logic [DATA_WIDTH-1:0]  o_IC_MEM_Data;

  logic                   i_DC_MEM_Valid;
  logic                   i_DC_MEM_Read_Write_n;
  logic [ADDRESS_WIDTH:0] i_DC_MEM_Address;
  logic [DATA_WIDTH-1:0]  i_DC_MEM_Data;
  logic                   o_DC_MEM_Valid;
  logic                   o_DC_MEM_Last;
  logic [DATA_WIDTH-1:0]  o_DC_MEM_Data;

  logic                   o_MEM_Valid;
  logic                   o_MEM_Read_Write_n;
  logic [ADDRESS_WIDTH:0] o_MEM_Address;
  logic [DATA_WIDTH-1:0]  o_MEM_Data;
  logic                   i_MEM_Valid;
  logic                   i_MEM_Last;
  logic [DATA_WIDTH-1:0]  i_MEM_Data;

  logic [1:0]             o_Grant;
  logic                   o_Burst_Error;

  modport master (
    input  i_IC_MEM_Valid, i_IC_MEM_Address,
    output o_IC_MEM_Valid, o_IC_MEM_Last, o_IC_MEM_Data,
    input  i_DC_MEM_Valid, i_DC_MEM_Read_Write_n, i_DC_MEM_Address, i_DC_MEM_Data,
    output o_DC_MEM_Valid, o_DC_MEM_Last, o_DC_MEM_Data,
    output o_MEM_Valid, o_MEM_Read_Write_n, o_MEM_Address, o_MEM_Data,
    input  i_MEM_Valid, i_MEM_Last, i_MEM_Data,
    output o_Grant, o_Burst_Error
  );

  modport slave (
    output i_IC_MEM_Valid, i_IC_MEM_Address,
    input  o_IC_MEM_Valid, o_IC_MEM_Last, o_IC_MEM_Data,
    output i_DC_MEM_Valid, i_DC_MEM_Read_Write_n, i_DC_MEM_Address, i_DC_MEM_Data,
    input  o_DC_MEM_Valid, o_DC_MEM_Last, o_DC_MEM_Data,
    input  o_MEM_Valid, o_MEM_Read_Write_n, o_MEM_Address, o_MEM_Data,
    output i_MEM_Valid, i_MEM_Last, i_MEM_Data,
    input  o_Grant, o_Burst_Error
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter for one shared memory burst port
// MEM_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise dcache wins ties.
module mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 21,
  parameter int BURST_LEN     = 4
) (
  input logic           i_Clk,
  input logic           i_Reset_n,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GRANT_IC = 2'b01,
    GRANT_DC = 2'b10
  } state_e;

  localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

  state_e     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic       burst_err_q, burst_err_d;
  logic       pick_dc;
  logic       at_last_beat;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 0 = icache served last, so the first tie after reset goes to the dcache.
  logic last_dc_q, last_dc_d;

  always_comb begin
    last_dc_d = last_dc_q;
    if (state_q == IDLE && state_d != IDLE) last_dc_d = (state_d == GRANT_DC);
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) last_dc_q <= 1'b0;
    else            last_dc_q <= last_dc_d;
  end

  assign pick_dc = bus.i_DC_MEM_Valid && (!bus.i_IC_MEM_Valid || !last_dc_q);
`else
  assign pick_dc = bus.i_DC_MEM_Valid;
`endif

  assign at_last_beat = (count_q == LAST_BEAT);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    burst_err_d = burst_err_q;
    case (state_q)
      IDLE: begin
        if (pick_dc) begin
          state_d = GRANT_DC;
          count_d = 3'd0;
        end else if (bus.i_IC_MEM_Valid) begin
          state_d = GRANT_IC;
          count_d = 3'd0;
        end
      end
      default: begin
        if (bus.i_MEM_Valid) begin
          count_d = count_q + 3'd1;
          // Short burst (early Last) or over-long burst (no Last on final beat).
          if (bus.i_MEM_Last != at_last_beat) burst_err_d = 1'b1;
          if (bus.i_MEM_Last || at_last_beat) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= IDLE;
      count_q     <= 3'd0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      burst_err_q <= burst_err_d;
    end
  end

  assign bus.o_IC_MEM_Data = bus.i_MEM_Data;
  assign bus.o_DC_MEM_Data = bus.i_MEM_Data;
  assign bus.o_Grant       = state_q;
  assign bus.o_Burst_Error = burst_err_q;

  always_comb begin
    bus.o_MEM_Valid        = 1'b0;
    bus.o_MEM_Read_Write_n = 1'b1;
    bus.o_MEM_Address      = '0;
    bus.o_MEM_Data         = '0;
    bus.o_IC_MEM_Valid     = 1'b0;
    bus.o_IC_MEM_Last      = 1'b0;
    bus.o_DC_MEM_Valid     = 1'b0;
    bus.o_DC_MEM_Last      = 1'b0;
    case (state_q)
      GRANT_IC: begin
        bus.o_MEM_Valid    = 1'b1;
        bus.o_MEM_Address  = bus.i_IC_MEM_Address;
        bus.o_IC_MEM_Valid = bus.i_MEM_Valid;
        bus.o_IC_MEM_Last  = bus.i_MEM_Last;
      end
      GRANT_DC: begin
        bus.o_MEM_Valid        = 1'b1;
        bus.o_MEM_Read_Write_n = bus.i_DC_MEM_Read_Write_n;
        bus.o_MEM_Address      = bus.i_DC_MEM_Address;
        bus.o_MEM_Data         = bus.i_DC_MEM_Data;
        bus.o_DC_MEM_Valid     = bus.i_MEM_Valid;
        bus.o_DC_MEM_Last      = bus.i_MEM_Last;
      end
      default: ;
    endcase
  end

endmodule
